iopage_bootmem: RTL and testbench

- Parametrised successor to the fixed iopage boot ROM.
- Holds a DEPTH-word shadow RAM in the iopage. After reset or on request, a copy engine fills it from one of several built-in boot images.
- Words can be patched through the iopage when write protect is off. The RK unit number is inserted into the RK image during the copy.
- Reads are registered and acknowledged, so the CPU bus waits while the image is being copied.

---
 rtl/iopage_bootmem_pkg.sv | 72 +++++++
 rtl/bootmem_ram.sv | 21 ++
 rtl/iopage_bootmem.sv | 151 +++++++++++++++
 tb/tb_iopage_bootmem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/iopage_bootmem_pkg.sv
// Shared constants, CSR layout, FSM states and built-in boot image tables for iopage_bootmem.
package iopage_bootmem_pkg;

    localparam int unsigned RK_LEN   = 24;
    localparam int unsigned CON_LEN  = 8;
    localparam int unsigned UNIT_IDX = 4;

    localparam int unsigned CSR_WP      = 0;
    localparam int unsigned CSR_IMG_LO  = 1;
    localparam int unsigned CSR_RELOAD  = 3;
    localparam int unsigned CSR_UNIT_LO = 8;
    localparam int unsigned CSR_BUSY    = 15;

    typedef enum logic {
        ST_COPY  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // RK05 bootstrap; word UNIT_IDX is the unit-number operand patched during copy.
    function automatic logic [15:0] rk_word(input logic [4:0] i);
        case (i)
            5'd0:    return 16'o042113;
            5'd1:    return 16'o012706;
            5'd2:    return 16'o002000;
            5'd3:    return 16'o012700;
            5'd4:    return 16'o000000;
            5'd5:    return 16'o010003;
            5'd6:    return 16'o000303;
            5'd7:    return 16'o006303;
            5'd8:    return 16'o006303;
            5'd9:    return 16'o006303;
            5'd10:   return 16'o006303;
            5'd11:   return 16'o006303;
            5'd12:   return 16'o012701;
            5'd13:   return 16'o177412;
            5'd14:   return 16'o010311;
            5'd15:   return 16'o005041;
            5'd16:   return 16'o012741;
            5'd17:   return 16'o177000;
            5'd18:   return 16'o012741;
            5'd19:   return 16'o000005;
            5'd20:   return 16'o105711;
            5'd21:   return 16'o100376;
            5'd22:   return 16'o105011;
            5'd23:   return 16'o005007;
            default: return 16'o000000;
        endcase
    endfunction

    // Console test: wait for the transmitter, print 'A', halt.
    function automatic logic [15:0] con_word(input logic [2:0] i);
        case (i)
            3'd0:    return 16'o012700;
            3'd1:    return 16'o177564;
            3'd2:    return 16'o105710;
            3'd3:    return 16'o100376;
            3'd4:    return 16'o112760;
            3'd5:    return 16'o000101;
            3'd6:    return 16'o000002;
            default: return 16'o000000;
        endcase
    endfunction

    function automatic logic [15:0] image_word(input logic [1:0] img, input logic [9:0] idx);
        case (img)
            2'd0:    return (32'(idx) < RK_LEN)  ? rk_word(idx[4:0])  : 16'o0;
            2'd1:    return (32'(idx) < CON_LEN) ? con_word(idx[2:0]) : 16'o0;
            default: return 16'o0;
        endcase
    endfunction

endpackage

// File: rtl/bootmem_ram.sv
// Single-port synchronous RAM, 16-bit words with per-byte write enables.
module bootmem_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    be,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (be[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/iopage_bootmem.sv
// Iopage shadow boot RAM: copy engine fills it from a built-in image, bus port reads/patches it.
module iopage_bootmem
    import iopage_bootmem_pkg::*;
#(
    parameter logic [12:0] BASE          = 13'o13000,
    parameter int unsigned DEPTH         = 256,
    parameter logic [12:0] CSR_ADDR      = 13'(BASE + 2 * DEPTH),
    parameter logic [1:0]  DEFAULT_IMAGE = 2'd0,
    parameter logic [2:0]  DEFAULT_UNIT  = 3'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    output logic [15:0] data_out,
    output logic        decode,
    output logic        ack,
    output logic        init_done
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [13:0] RAM_END = 14'(BASE) + 14'(2 * DEPTH);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          wp;
    logic [1:0]    img;
    logic [1:0]    copy_img;
    logic [2:0]    unit;
    logic          hold;
    logic          sel_csr, sel_rd, sel_byte, sel_odd;
    logic [15:0]   csr_q;

    logic          strobe, ram_hit, csr_hit, accept, csr_wr, reload;
    logic [1:0]    be_bus;
    logic [AW-1:0] word_idx;
    logic [15:0]   csr_word, copy_word, rd_word;
    logic          wp_n;
    logic [1:0]    img_n;
    logic [2:0]    unit_n;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata, ram_rdata;
    logic [1:0]    ram_be;

    // Address decode, request acceptance and CSR next values.
    always_comb begin
        strobe   = iopage_rd | iopage_wr;
        ram_hit  = (iopage_addr >= BASE) && (14'(iopage_addr) < RAM_END);
        csr_hit  = iopage_addr[12:1] == CSR_ADDR[12:1];
        decode   = ram_hit | csr_hit;
        accept   = strobe & ~hold & (csr_hit | (ram_hit & (state == ST_READY)));
        be_bus   = iopage_byte_op ? (iopage_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        word_idx = AW'((iopage_addr - BASE) >> 1);

        csr_word             = '0;
        csr_word[CSR_WP]     = wp;
        csr_word[CSR_IMG_LO +: 2]  = img;
        csr_word[CSR_UNIT_LO +: 3] = unit;
        csr_word[CSR_BUSY]   = state == ST_COPY;

        csr_wr = accept & iopage_wr & csr_hit;
        wp_n   = (csr_wr & be_bus[0]) ? data_in[CSR_WP] : wp;
        img_n  = (csr_wr & be_bus[0]) ? data_in[CSR_IMG_LO +: 2] : img;
        unit_n = (csr_wr & be_bus[1]) ? data_in[CSR_UNIT_LO +: 3] : unit;
        reload = csr_wr & be_bus[0] & data_in[CSR_RELOAD] & (state == ST_READY);
    end

    // The copy engine owns the RAM port while copying; the bus gets it otherwise.
    always_comb begin
        copy_word = image_word(copy_img, 10'(cnt));
        if (copy_img == 2'd0 && cnt == AW'(UNIT_IDX)) copy_word = {13'b0, unit};
        ram_addr  = word_idx;
        ram_wdata = data_in;
        ram_be    = '0;
        if (state == ST_COPY) begin
            ram_addr  = cnt;
            ram_wdata = copy_word;
            ram_be    = 2'b11;
        end else if (accept & iopage_wr & ~csr_hit & ~wp) begin
            ram_be = be_bus;
        end
    end

    bootmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_COPY;
            cnt       <= '0;
            init_done <= 1'b0;
            wp        <= 1'b1;
            img       <= DEFAULT_IMAGE;
            copy_img  <= DEFAULT_IMAGE;
            unit      <= DEFAULT_UNIT;
            ack       <= 1'b0;
            hold      <= 1'b0;
            sel_csr   <= 1'b0;
            sel_rd    <= 1'b0;
            sel_byte  <= 1'b0;
            sel_odd   <= 1'b0;
            csr_q     <= '0;
        end else begin
            ack  <= accept;
            // A held strobe is acknowledged once; it must drop before the next request.
            hold <= accept | (hold & strobe);
            if (accept) begin
                sel_csr  <= csr_hit;
                sel_rd   <= ~iopage_wr;
                sel_byte <= iopage_byte_op;
                sel_odd  <= iopage_addr[0];
                csr_q    <= csr_word;
            end
            wp   <= wp_n;
            img  <= img_n;
            unit <= unit_n;
            case (state)
                ST_COPY: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    if (reload) begin
                        state     <= ST_COPY;
                        cnt       <= '0;
                        init_done <= 1'b0;
                        copy_img  <= img_n;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd_word  = sel_csr ? csr_q : ram_rdata;
        data_out = '0;
        if (ack & sel_rd) data_out = sel_byte ? {8'b0, sel_odd ? rd_word[15:8] : rd_word[7:0]} : rd_word;
    end

endmodule

// File: tb/tb_iopage_bootmem.sv
// Directed bench for iopage_bootmem: copy timing, bus handshake, write protect, byte lanes, reload and reset.
module tb_iopage_bootmem;

    localparam logic [12:0] BASE = 13'o13000;
    localparam logic [12:0] CSR  = 13'o14000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] iopage_addr = '0;
    logic [15:0] data_in = '0;
    logic        iopage_rd = 1'b0;
    logic        iopage_wr = 1'b0;
    logic        iopage_byte_op = 1'b0;
    logic [15:0] data_out;
    logic        decode, ack, init_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iopage_bootmem #(.BASE(BASE), .DEPTH(256)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .iopage_addr    (iopage_addr),
        .data_in        (data_in),
        .iopage_rd      (iopage_rd),
        .iopage_wr      (iopage_wr),
        .iopage_byte_op (iopage_byte_op),
        .data_out       (data_out),
        .decode         (decode),
        .ack            (ack),
        .init_done      (init_done)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06o expected %06o", tag, got, exp);
        end
    endtask

    task automatic bus_op(input logic wr, input logic [12:0] a, input logic [15:0] d,
                          input logic bop, output logic [15:0] q, output int lat);
        @(negedge clk);
        iopage_addr    = a;
        data_in        = d;
        iopage_byte_op = bop;
        iopage_wr      = wr;
        iopage_rd      = ~wr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 2000);
        q = data_out;
        if (!ack) check("bus_timeout", 16'(ack), 16'd1);
        @(negedge clk);
        iopage_rd = 1'b0;
        iopage_wr = 1'b0;
        iopage_byte_op = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!init_done && n < 5000);
    endtask

    logic [12:0] dec_addr [5] = '{BASE - 13'd2, BASE, BASE + 13'o776, CSR, CSR + 13'd2};
    logic        dec_exp  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [15:0] q;
        int          lat, n;
        logic        seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 16'(ack), 16'd0);
        check("rst_dout", data_out, 16'o0);
        check("rst_init", 16'(init_done), 16'd0);
        @(negedge clk) reset_n = 1'b1;

        wait_init(n);
        check("copy_cycles", 16'(n), 16'd256);
        bus_op(1'b0, BASE + 13'd2, 16'o0, 1'b0, q, lat);
        check("rd_w1", q, 16'o012706);
        check("rd_w1_lat", 16'(lat), 16'd1);

        // Strobe held for several cycles gets exactly one ack.
        @(negedge clk);
        iopage_addr = BASE + 13'd2;
        iopage_rd   = 1'b1;
        @(posedge clk); #1;
        check("held_ack1", 16'(ack), 16'd1);
        @(posedge clk); #1;
        check("held_ack2", 16'(ack), 16'd0);
        check("held_dout", data_out, 16'o0);
        @(posedge clk); #1;
        check("held_ack3", 16'(ack), 16'd0);
        @(negedge clk) iopage_rd = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk) iopage_addr = dec_addr[i];
            #1 check($sformatf("decode_%0d", i), 16'(decode), 16'(dec_exp[i]));
        end

        @(negedge clk);
        iopage_addr = BASE - 13'd2;
        iopage_rd   = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack || data_out != 16'o0) seen = 1'b1;
        end
        check("nodecode_ack", 16'(seen), 16'd0);
        @(negedge clk) iopage_rd = 1'b0;

        bus_op(1'b1, CSR, 16'o001410, 1'b0, q, lat);
        check("csr_wr_lat", 16'(lat), 16'd1);
        bus_op(1'b0, CSR, 16'o0, 1'b0, q, lat);
        check("csr_busy", q, 16'o101400);
        bus_op(1'b0, BASE + 13'd4, 16'o0, 1'b0, q, lat);
        check("copy_hold_data", q, 16'o002000);
        check("copy_hold_init", 16'(init_done), 16'd1);
        check("copy_hold_lat", 16'(lat > 2), 16'd1);
        bus_op(1'b0, BASE + 13'd8, 16'o0, 1'b0, q, lat);
        check("rk_unit", q, 16'o000003);

        bus_op(1'b1, CSR, 16'o001401, 1'b0, q, lat);
        bus_op(1'b1, BASE + 13'd10, 16'o123456, 1'b0, q, lat);
        check("wp_wr_lat", 16'(lat), 16'd1);
        bus_op(1'b0, BASE + 13'd10, 16'o0, 1'b0, q, lat);
        check("wp_protect", q, 16'o010003);
        bus_op(1'b1, CSR, 16'o001400, 1'b0, q, lat);
        bus_op(1'b1, BASE + 13'd10, 16'o123456, 1'b0, q, lat);
        bus_op(1'b0, BASE + 13'd10, 16'o0, 1'b0, q, lat);
        check("wp_patch", q, 16'o123456);

        bus_op(1'b0, BASE + 13'd3, 16'o0, 1'b1, q, lat);
        check("byte_rd_hi", q, 16'o000025);
        bus_op(1'b0, BASE + 13'd2, 16'o0, 1'b1, q, lat);
        check("byte_rd_lo", q, 16'o000306);
        bus_op(1'b1, BASE + 13'd3, 16'hFFFF, 1'b1, q, lat);
        bus_op(1'b0, BASE + 13'd2, 16'o0, 1'b0, q, lat);
        check("byte_wr_hi", q, 16'o177706);

        bus_op(1'b1, CSR + 13'd1, 16'h05FF, 1'b1, q, lat);
        bus_op(1'b0, CSR, 16'o0, 1'b0, q, lat);
        check("csr_byte_wr", q, 16'o002400);
        bus_op(1'b0, CSR + 13'd1, 16'o0, 1'b1, q, lat);
        check("csr_byte_rd", q, 16'o000005);

        // Second reload lands mid-copy and must not restart it.
        bus_op(1'b1, CSR, 16'o002414, 1'b0, q, lat);
        bus_op(1'b1, CSR, 16'o002414, 1'b0, q, lat);
        wait_init(n);
        check("reload_ignored", 16'(n), 16'd254);
        bus_op(1'b0, BASE + 13'd2, 16'o0, 1'b0, q, lat);
        check("img2_zero", q, 16'o0);

        bus_op(1'b1, CSR, 16'o002412, 1'b0, q, lat);
        wait_init(n);
        bus_op(1'b0, BASE, 16'o0, 1'b0, q, lat);
        check("img1_w0", q, 16'o012700);
        bus_op(1'b0, BASE + 13'd8, 16'o0, 1'b0, q, lat);
        check("img1_w4", q, 16'o112760);

        bus_op(1'b1, CSR, 16'o002412, 1'b0, q, lat);
        repeat (100) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("midreset_init", 16'(init_done), 16'd0);
        check("midreset_ack", 16'(ack), 16'd0);
        @(negedge clk) reset_n = 1'b1;
        bus_op(1'b0, CSR, 16'o0, 1'b0, q, lat);
        check("midreset_csr", q, 16'o100001);
        wait_init(n);
        bus_op(1'b0, BASE + 13'd2, 16'o0, 1'b0, q, lat);
        check("midreset_w1", q, 16'o012706);
        bus_op(1'b0, BASE + 13'd8, 16'o0, 1'b0, q, lat);
        check("midreset_w4", q, 16'o000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
